rs_issue_scheduler: RTL and testbench

- Reservation-station buffer and issue scheduler that sits between the dispatch unit and one functional unit (ALU or FPU).
- Accepts dispatched instructions whose operands carry either a value (ready) or a 3-bit producer tag (waiting).
- Captures results broadcast on the CDB and issues the oldest fully-ready entry to the functional unit using a valid/ready handshake.

---
 rtl/rs_pkg.sv | 50 +++++
 rtl/rs_oldest_ready_select.sv | 27 ++
 rtl/rs_issue_scheduler.sv | 176 +++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation-station issue scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rs_pkg;

    localparam int DATA_W  = 32;
    localparam int TAG_W   = 3;
    localparam int OPC_W   = 5;
    localparam int NUM_OPS = 3;

    typedef struct packed {
        logic [DATA_W-1:0] val;
        logic [TAG_W-1:0]  tag;
        logic              rdy;
    } rs_operand_t;

    typedef struct packed {
        logic                            valid;
        logic [OPC_W-1:0]                opcode;
        logic [TAG_W-1:0]                dest_tag;
        rs_operand_t [NUM_OPS-1:0]       op;
    } rs_entry_t;

    // True when a still-waiting operand is satisfied by the current broadcast.
    function automatic logic operand_hit(
        input logic             rdy,
        input logic [TAG_W-1:0] tag,
        input logic             cdb_valid,
        input logic [TAG_W-1:0] cdb_tag
    );
        return !rdy && cdb_valid && (tag == cdb_tag);
    endfunction

    // Returns the operand after capturing a matching broadcast, if any.
    function automatic rs_operand_t operand_wakeup(
        input rs_operand_t       op,
        input logic              cdb_valid,
        input logic [TAG_W-1:0]  cdb_tag,
        input logic [DATA_W-1:0] cdb_data
    );
        rs_operand_t r;
        r = op;
        if (operand_hit(op.rdy, op.tag, cdb_valid, cdb_tag)) begin
            r.rdy = 1'b1;
            r.val = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_oldest_ready_select.sv
// Picks the lowest-index (oldest) set bit of an eligibility vector.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rs_oldest_ready_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         elig,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    // Isolate the lowest set bit and encode its position.
    always_comb begin
        grant = elig & (~elig + N'(1));
        any   = |elig;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Age-ordered reservation station: captures CDB results, issues oldest ready entry.
// Latency: dispatch-to-issue 1 cycle when ready; wakeup-to-issue 1 cycle (0 with RS_WAKEUP_ISSUE_EN).
// Backpressure: disp_ready drops at DEPTH entries; issue holds valid until issue_ready.
module rs_issue_scheduler
    import rs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [OPC_W-1:0]             disp_opcode,
    input  logic [TAG_W-1:0]             disp_dest_tag,
    input  logic [DATA_W-1:0]            disp_op1_val,
    input  logic [TAG_W-1:0]             disp_op1_tag,
    input  logic                         disp_op1_ready,
    input  logic [DATA_W-1:0]            disp_op2_val,
    input  logic [TAG_W-1:0]             disp_op2_tag,
    input  logic                         disp_op2_ready,
    input  logic [DATA_W-1:0]            disp_op3_val,
    input  logic [TAG_W-1:0]             disp_op3_tag,
    input  logic                         disp_op3_ready,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [DATA_W-1:0]            cdb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [OPC_W-1:0]             issue_opcode,
    output logic [TAG_W-1:0]             issue_dest_tag,
    output logic [DATA_W-1:0]            issue_op1_val,
    output logic [DATA_W-1:0]            issue_op2_val,
    output logic [DATA_W-1:0]            issue_op3_val,
    output logic [$clog2(DEPTH+1)-1:0]   rs_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t                          slot_q  [DEPTH];
    rs_entry_t                          slot_d  [DEPTH];
    rs_entry_t                          shifted [DEPTH];
    rs_entry_t                          disp_entry;
    logic [CNT_W-1:0]                   count_q;
    logic [CNT_W-1:0]                   count_d;
    logic [CNT_W-1:0]                   wr_slot;
    logic [DEPTH-1:0]                   elig;
    logic [DEPTH-1:0]                   grant;
    logic [IDX_W-1:0]                   sel_idx;
    logic                               any_elig;
    logic                               issue_fire;
    logic                               disp_fire;
    logic [NUM_OPS-1:0][DATA_W-1:0]     sel_val;

    assign disp_ready = (count_q < CNT_W'(DEPTH));
    assign rs_count   = count_q;
    assign issue_valid = any_elig;

    // Flush wins over both handshakes; a full RS never takes a dispatch even if it issues.
    assign issue_fire = any_elig && issue_ready && !flush;
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign wr_slot    = count_q - CNT_W'(issue_fire);

    // An entry is eligible once all three operands are available.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = slot_q[i].valid;
            for (int n = 0; n < NUM_OPS; n++) begin
`ifdef RS_WAKEUP_ISSUE_EN
                elig[i] = elig[i] & (slot_q[i].op[n].rdy |
                          operand_hit(slot_q[i].op[n].rdy, slot_q[i].op[n].tag, cdb_valid, cdb_tag));
`else
                elig[i] = elig[i] & slot_q[i].op[n].rdy;
`endif
            end
        end
    end

    rs_oldest_ready_select #(
        .N (DEPTH)
    ) u_select (
        .elig  (elig),
        .grant (grant),
        .idx   (sel_idx),
        .any   (any_elig)
    );

    // Drive the issue port from the granted slot; zeros when nothing is eligible.
    always_comb begin
        issue_opcode   = '0;
        issue_dest_tag = '0;
        sel_val        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_opcode   = slot_q[i].opcode;
                issue_dest_tag = slot_q[i].dest_tag;
                for (int n = 0; n < NUM_OPS; n++) begin
`ifdef RS_WAKEUP_ISSUE_EN
                    sel_val[n] = operand_hit(slot_q[i].op[n].rdy, slot_q[i].op[n].tag, cdb_valid, cdb_tag)
                                 ? cdb_data : slot_q[i].op[n].val;
`else
                    sel_val[n] = slot_q[i].op[n].val;
`endif
                end
            end
        end
    end

    assign issue_op1_val = sel_val[0];
    assign issue_op2_val = sel_val[1];
    assign issue_op3_val = sel_val[2];

    // Assemble the incoming entry; broadcast capture happens with the rest of the slots.
    always_comb begin
        disp_entry.valid    = 1'b1;
        disp_entry.opcode   = disp_opcode;
        disp_entry.dest_tag = disp_dest_tag;
        disp_entry.op[0]    = '{val: disp_op1_val, tag: disp_op1_tag, rdy: disp_op1_ready};
        disp_entry.op[1]    = '{val: disp_op2_val, tag: disp_op2_tag, rdy: disp_op2_ready};
        disp_entry.op[2]    = '{val: disp_op3_val, tag: disp_op3_tag, rdy: disp_op3_ready};
    end

    // Each slot's view of its upper neighbour, used when an older entry leaves.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = slot_q[i + 1];
        end
        shifted[DEPTH-1] = '0;
    end

    // Next slot contents: compact around the issued entry, append dispatch, then wake up.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (issue_fire && (i >= int'(sel_idx))) begin
                slot_d[i] = shifted[i];
            end
            if (disp_fire && (CNT_W'(i) == wr_slot)) begin
                slot_d[i] = disp_entry;
            end
            if (slot_d[i].valid) begin
                for (int n = 0; n < NUM_OPS; n++) begin
                    slot_d[i].op[n] = operand_wakeup(slot_d[i].op[n], cdb_valid, cdb_tag, cdb_data);
                end
            end
            if (flush) begin
                slot_d[i] = '0;
            end
        end
    end

    // Occupancy follows the accepted handshakes.
    always_comb begin
        count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        if (flush) begin
            count_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench with an in-bench queue model of the reservation station.
// Latency: n/a.
// Backpressure: n/a.
module tb_rs_issue_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  disp_opcode;
    logic [2:0]  disp_dest_tag;
    logic [31:0] disp_op1_val, disp_op2_val, disp_op3_val;
    logic [2:0]  disp_op1_tag, disp_op2_tag, disp_op3_tag;
    logic        disp_op1_ready, disp_op2_ready, disp_op3_ready;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_opcode;
    logic [2:0]  issue_dest_tag;
    logic [31:0] issue_op1_val, issue_op2_val, issue_op3_val;
    logic [2:0]  rs_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_issue_scheduler #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_opcode    (disp_opcode),
        .disp_dest_tag  (disp_dest_tag),
        .disp_op1_val   (disp_op1_val),
        .disp_op1_tag   (disp_op1_tag),
        .disp_op1_ready (disp_op1_ready),
        .disp_op2_val   (disp_op2_val),
        .disp_op2_tag   (disp_op2_tag),
        .disp_op2_ready (disp_op2_ready),
        .disp_op3_val   (disp_op3_val),
        .disp_op3_tag   (disp_op3_tag),
        .disp_op3_ready (disp_op3_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_opcode   (issue_opcode),
        .issue_dest_tag (issue_dest_tag),
        .issue_op1_val  (issue_op1_val),
        .issue_op2_val  (issue_op2_val),
        .issue_op3_val  (issue_op3_val),
        .rs_count       (rs_count)
    );

    // Model: one record per occupied entry, oldest at the front of the queue.
    typedef struct packed {
        logic [4:0]       opc;
        logic [2:0]       dest;
        logic [2:0][31:0] val;
        logic [2:0][2:0]  tag;
        logic [2:0]       rdy;
    } m_ent_t;

    m_ent_t mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic m_ent_t m_wake(input m_ent_t e);
        m_ent_t r = e;
        for (int n = 0; n < 3; n++) begin
            if (!r.rdy[n] && cdb_valid && r.tag[n] == cdb_tag) begin
                r.rdy[n] = 1'b1;
                r.val[n] = cdb_data;
            end
        end
        return r;
    endfunction

    function automatic logic m_avail(input m_ent_t e, input int n);
`ifdef RS_WAKEUP_ISSUE_EN
        return e.rdy[n] || (cdb_valid && e.tag[n] == cdb_tag);
`else
        return e.rdy[n];
`endif
    endfunction

    function automatic logic [31:0] m_opval(input m_ent_t e, input int n);
`ifdef RS_WAKEUP_ISSUE_EN
        return e.rdy[n] ? e.val[n] : cdb_data;
`else
        return e.val[n];
`endif
    endfunction

    // Compare DUT to model mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin : model_cmp
        int     sel;
        logic   accept;
        m_ent_t ne;
        if (rst) begin
            mq.delete();
            chk("rst_issue_valid", 32'(issue_valid), 32'd0);
            chk("rst_rs_count", 32'(rs_count), 32'd0);
            chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        end else begin
            sel = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (sel < 0 && m_avail(mq[i], 0) && m_avail(mq[i], 1) && m_avail(mq[i], 2)) sel = i;
            end
            chk("m_issue_valid", 32'(issue_valid), 32'(sel >= 0));
            chk("m_rs_count", 32'(rs_count), 32'(mq.size()));
            chk("m_disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
            if (sel >= 0) begin
                chk("m_opcode", 32'(issue_opcode), 32'(mq[sel].opc));
                chk("m_dest_tag", 32'(issue_dest_tag), 32'(mq[sel].dest));
                chk("m_op1", issue_op1_val, m_opval(mq[sel], 0));
                chk("m_op2", issue_op2_val, m_opval(mq[sel], 1));
                chk("m_op3", issue_op3_val, m_opval(mq[sel], 2));
            end
            if (flush) begin
                mq.delete();
            end else begin
                accept = disp_valid && (mq.size() < DEPTH);
                if (sel >= 0 && issue_ready) mq.delete(sel);
                foreach (mq[i]) mq[i] = m_wake(mq[i]);
                if (accept) begin
                    ne.opc  = disp_opcode;
                    ne.dest = disp_dest_tag;
                    ne.val  = {disp_op3_val, disp_op2_val, disp_op1_val};
                    ne.tag  = {disp_op3_tag, disp_op2_tag, disp_op1_tag};
                    ne.rdy  = {disp_op3_ready, disp_op2_ready, disp_op1_ready};
                    mq.push_back(m_wake(ne));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid  = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
        issue_ready = 1'b0;
    endtask

    task automatic set_disp(input logic [4:0] opc, input logic [2:0] dest,
                            input logic [31:0] v1, input logic [2:0] t1, input logic r1,
                            input logic [31:0] v2, input logic [2:0] t2, input logic r2,
                            input logic [31:0] v3, input logic [2:0] t3, input logic r3);
        disp_valid    = 1'b1;
        disp_opcode   = opc;
        disp_dest_tag = dest;
        disp_op1_val = v1; disp_op1_tag = t1; disp_op1_ready = r1;
        disp_op2_val = v2; disp_op2_tag = t2; disp_op2_ready = r2;
        disp_op3_val = v3; disp_op3_tag = t3; disp_op3_ready = r3;
    endtask

    task automatic disp_rdy(input logic [4:0] opc, input logic [2:0] dest,
                            input logic [31:0] v1, input logic [31:0] v2);
        set_disp(opc, dest, v1, 3'd0, 1'b1, v2, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_disp(5'd0, 3'd0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0);
        disp_valid = 1'b0;
        cdb_tag    = 3'd0;
        cdb_data   = 32'd0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("L_reset_disp_ready", 32'(disp_ready), 32'd1);
        chk("L_reset_issue_valid", 32'(issue_valid), 32'd0);
        chk("L_reset_rs_count", 32'(rs_count), 32'd0);
        chk("L_reset_op1", issue_op1_val, 32'd0);

        // Single all-ready ADD.
        disp_rdy(5'd1, 3'd2, 32'd5, 32'd7);
        cyc(); idle();
        chk("L_add_valid", 32'(issue_valid), 32'd1);
        chk("L_add_op1", issue_op1_val, 32'd5);
        chk("L_add_op2", issue_op2_val, 32'd7);
        chk("L_add_dest", 32'(issue_dest_tag), 32'd2);
        issue_ready = 1'b1;
        cyc(); idle();
        chk("L_add_drained", 32'(rs_count), 32'd0);

        // Operand waiting on tag 3, woken two cycles later.
        set_disp(5'd2, 3'd5, 32'd0, 3'd3, 1'b0, 32'd1, 3'd0, 1'b1, 32'd2, 3'd0, 1'b1);
        cyc(); idle();
        chk("L_wait_blocked", 32'(issue_valid), 32'd0);
        cyc();
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'hDEAD;
        #1;
`ifdef RS_WAKEUP_ISSUE_EN
        chk("L_wake_same_cycle", 32'(issue_valid), 32'd1);
        chk("L_wake_fwd_op1", issue_op1_val, 32'hDEAD);
`else
        chk("L_wake_bubble", 32'(issue_valid), 32'd0);
`endif
        cyc(); idle();
        chk("L_wake_valid", 32'(issue_valid), 32'd1);
        chk("L_wake_op1", issue_op1_val, 32'hDEAD);
        issue_ready = 1'b1;
        cyc(); idle();

        // Fill, overflow attempt, then one issue.
        for (int k = 0; k < 4; k++) begin
            disp_rdy(5'd3, 3'(k), 32'(10 + k), 32'd0);
            cyc();
        end
        idle();
        chk("L_full_count", 32'(rs_count), 32'd4);
        chk("L_full_disp_ready", 32'(disp_ready), 32'd0);
        disp_rdy(5'd3, 3'd7, 32'd99, 32'd0);
        cyc(); idle();
        chk("L_overflow_count", 32'(rs_count), 32'd4);
        chk("L_oldest_op1", issue_op1_val, 32'd10);
        issue_ready = 1'b1;
        cyc(); idle();
        chk("L_after_issue_count", 32'(rs_count), 32'd3);
        chk("L_after_issue_disp_ready", 32'(disp_ready), 32'd1);
        chk("L_next_oldest_op1", issue_op1_val, 32'd11);
        issue_ready = 1'b1;
        repeat (3) cyc();
        idle();
        chk("L_drain_count", 32'(rs_count), 32'd0);

        // Older waiting entry is bypassed, then issues once woken.
        set_disp(5'd4, 3'd1, 32'd0, 3'd6, 1'b0, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1);
        cyc();
        disp_rdy(5'd4, 3'd2, 32'h22, 32'd0);
        cyc(); idle();
        chk("L_young_first_dest", 32'(issue_dest_tag), 32'd2);
        chk("L_young_first_op1", issue_op1_val, 32'h22);
        issue_ready = 1'b1;
        cyc(); idle();
        chk("L_old_left_count", 32'(rs_count), 32'd1);
        chk("L_old_blocked", 32'(issue_valid), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'h66;
        cyc(); idle();
        chk("L_old_valid", 32'(issue_valid), 32'd1);
        chk("L_old_dest", 32'(issue_dest_tag), 32'd1);
        chk("L_old_op1", issue_op1_val, 32'h66);
        issue_ready = 1'b1;
        cyc(); idle();

        // Capture of a broadcast in the dispatch cycle.
        set_disp(5'd5, 3'd3, 32'd3, 3'd0, 1'b1, 32'd0, 3'd4, 1'b0, 32'd0, 3'd0, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'h11;
        cyc(); idle();
        chk("L_capture_valid", 32'(issue_valid), 32'd1);
        chk("L_capture_op2", issue_op2_val, 32'h11);
        chk("L_capture_op1", issue_op1_val, 32'd3);
        issue_ready = 1'b1;
        cyc(); idle();

        // Flush with a simultaneous dispatch and issue request.
        for (int k = 0; k < 3; k++) begin
            disp_rdy(5'd6, 3'(k), 32'(20 + k), 32'd0);
            cyc();
        end
        idle();
        chk("L_pre_flush_count", 32'(rs_count), 32'd3);
        disp_rdy(5'd6, 3'd0, 32'h77, 32'd0);
        flush = 1'b1; issue_ready = 1'b1;
        cyc(); idle();
        chk("L_flush_count", 32'(rs_count), 32'd0);
        chk("L_flush_valid", 32'(issue_valid), 32'd0);
        chk("L_flush_disp_ready", 32'(disp_ready), 32'd1);

        // Asynchronous reset while an issue is being offered.
        disp_rdy(5'd7, 3'd3, 32'h5A, 32'd1);
        cyc(); idle();
        issue_ready = 1'b1;
        #1;
        chk("L_pre_rst_valid", 32'(issue_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("L_rst_valid", 32'(issue_valid), 32'd0);
        chk("L_rst_count", 32'(rs_count), 32'd0);
        chk("L_rst_op1", issue_op1_val, 32'd0);
        chk("L_rst_dest", 32'(issue_dest_tag), 32'd0);
        chk("L_rst_disp_ready", 32'(disp_ready), 32'd1);
        cyc();
        rst = 1'b0;
        idle();
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
